rob_commit_ctrl: RTL and testbench
==================================

// Module: rob_commit_ctrl
// PURPOSE
//  Retire side of the ROB: watches the two oldest robentry slots at the head, asserts their
//  commit strobes in program order (up to 2/cycle), returns old_prd to the freelist, writes
//  the architectural RAT and advances the head pointer. Also owns flush recovery of the head,
//  the retired-instruction counter and a head-stall watchdog. Sits between the robentry array and the rename freelist/arch RAT.
// PARAMETERS
//  ROB_SIZE   64    number of robentry slots, power of two
//  IDX_W      6     log2(ROB_SIZE); head pointer = {wrap bit, IDX_W index}
//  WDOG_LIMIT 1023  head-not-complete cycles before deadlock flag (max 65535)
// PORTS
//  clock            in   1           core clock
//  reset_n          in   1           async active-low reset
//  flush            in   1           pipeline flush (same cycle robentry clears)
//  head0_valid      in   1           valid of entry at head_ptr
//  head0_deq        in   1           deq (valid&complete) of entry at head_ptr
//  head0_pc/instr   in   PC_RANGE/32 pc and instr of head entry
//  head0_lrd        in   LREG_RANGE  logical rd of head entry
//  head0_prd        in   PREG_RANGE  physical rd of head entry
//  head0_old_prd    in   PREG_RANGE  previous mapping of lrd
//  head0_need_to_wb in   1           entry writes a register
//  head0_skip       in   1           difftest skip
//  head1_*          in   same        identical set for entry head_ptr+1 (mod ROB_SIZE); no head1_valid
//  fl_ready         in   1           freelist can accept 2 pushes this cycle
//  commit_vec       out  ROB_SIZE    per-entry commit strobes to robentry array
//  head_ptr         out  IDX_W+1     head pointer incl. wrap bit
//  fl_push0/1       out  1           freelist push valid, slot 0/1
//  fl_push0/1_preg  out  PREG_RANGE  preg returned (old_prd)
//  art_we0/1        out  1           arch RAT write enable, slot 0/1
//  art_waddr0/1     out  LREG_RANGE  arch RAT address (lrd)
//  art_wdata0/1     out  PREG_RANGE  arch RAT data (prd)
//  rt_valid0/1      out  1           registered retire report (difftest)
//  rt_pc0/1, rt_instr0/1, rt_skip0/1  out  PC_RANGE/32/1  registered retire info
//  retire_cnt       out  64          total retired instructions
//  deadlock         out  1           sticky watchdog flag
// BEHAVIOUR
//  Reset: head_ptr=0, retire_cnt=0, deadlock=0, all rt_* =0, FSM=RUN; comb outputs 0.
//  FSM: RUN; HALT entered when flush=1 (any state); HALT while flush=1, plus one cycle after
//   flush falls; then RUN. No commit in HALT or in any cycle with flush=1.
//  Commit (comb, same cycle): c0 = RUN & ~flush & head0_deq & fl_ready;
//   c1 = c0 & head1_deq. Slot 1 never commits without slot 0 (in order).
//  commit_vec: bit head idx = c0, bit (idx+1) mod ROB_SIZE = c1; all others 0.
//  fl_pushN = cN & headN_need_to_wb & (headN_lrd!=0); preg = headN_old_prd.
//  art_weN same condition as fl_pushN; waddr=lrd, wdata=prd. If both slots write the
//   same lrd, slot1 wins (RAT owner resolves; both enables asserted).
//  Head: next = head_ptr + c0 + c1, IDX_W+1 bit arithmetic, wrap bit toggles on index wrap.
//   On flush: head_ptr <= 0 at next edge (ROB is empty after flush).
//  retire_cnt += c0+c1 each edge, 64-bit wrapping.
//  rt_*: registered copy of cN and slot info, 1-cycle latency after commit; cleared on flush.
//  Watchdog: 16-bit cnt increments while RUN & head0_valid & ~c0, clears on c0 or flush;
//   reaching WDOG_LIMIT sets deadlock, held until reset. fl_ready=0 counts as stall.
//  Reset mid-operation: all state to reset values asynchronously; no partial commit.
// TESTING
//  head0_deq=1,head1_deq=1,fl_ready=1,head=5 -> commit_vec bits5,6; head_ptr=7; retire_cnt+2
//  head=63 (wrap=0), both deq -> bits 63 and 0 set; next head_ptr={1,1}
//  head0_deq=0,head1_deq=1 -> commit_vec=0, no push, head unchanged
//  lrd0=0 need_to_wb=1 -> c0=1, fl_push0=0, art_we0=0; lrd=3 old_prd=17 -> fl_push0_preg=17
//  flush 2 cycles with deq=1 -> no commit for 3 cycles, head_ptr=0, rt_valid=0
//  head0_valid=1 never complete, WDOG_LIMIT=8 -> deadlock=1 after 8 cycles, stays set

Source files
------------

// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl
//   Retire side of the ROB. Looks at the two oldest entries (head, head+1) and
//   commits them in program order, up to two per cycle. Each commit:
//     - pulses that entry's bit in commit_vec
//     - returns old_prd to the freelist
//     - writes lrd->prd into the architectural RAT
//     - advances head_ptr
//   Also handles flush recovery of the head, counts retired instructions and
//   runs a watchdog on a head entry that never completes.
// Ports
//   clock, reset_n         core clock, async active-low reset
//   flush                  pipeline flush; ROB is empty on the following edge
//   head0_* / head1_*      state of entries head_ptr and head_ptr+1
//   fl_ready               freelist can take two pushes this cycle
//   commit_vec             per-entry commit strobes (combinational)
//   head_ptr               {wrap, index}
//   fl_push*/art_*         freelist return / arch RAT write, slots 0/1 (comb)
//   rt_*                   registered retire report, one cycle after commit
//   retire_cnt             64-bit wrapping retired-instruction count
//   deadlock               sticky watchdog flag
module rob_commit_ctrl #(
    parameter int ROB_SIZE   = 64,
    parameter int IDX_W      = 6,
    parameter int WDOG_LIMIT = 1023,
    parameter int PC_W       = 39,
    parameter int LREG_W     = 5,
    parameter int PREG_W     = 7
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                head0_valid,
    input  logic                head0_deq,
    input  logic [PC_W-1:0]     head0_pc,
    input  logic [31:0]         head0_instr,
    input  logic [LREG_W-1:0]   head0_lrd,
    input  logic [PREG_W-1:0]   head0_prd,
    input  logic [PREG_W-1:0]   head0_old_prd,
    input  logic                head0_need_to_wb,
    input  logic                head0_skip,
    input  logic                head1_deq,
    input  logic [PC_W-1:0]     head1_pc,
    input  logic [31:0]         head1_instr,
    input  logic [LREG_W-1:0]   head1_lrd,
    input  logic [PREG_W-1:0]   head1_prd,
    input  logic [PREG_W-1:0]   head1_old_prd,
    input  logic                head1_need_to_wb,
    input  logic                head1_skip,
    input  logic                fl_ready,
    output logic [ROB_SIZE-1:0] commit_vec,
    output logic [IDX_W:0]      head_ptr,
    output logic                fl_push0,
    output logic [PREG_W-1:0]   fl_push0_preg,
    output logic                fl_push1,
    output logic [PREG_W-1:0]   fl_push1_preg,
    output logic                art_we0,
    output logic [LREG_W-1:0]   art_waddr0,
    output logic [PREG_W-1:0]   art_wdata0,
    output logic                art_we1,
    output logic [LREG_W-1:0]   art_waddr1,
    output logic [PREG_W-1:0]   art_wdata1,
    output logic                rt_valid0,
    output logic [PC_W-1:0]     rt_pc0,
    output logic [31:0]         rt_instr0,
    output logic                rt_skip0,
    output logic                rt_valid1,
    output logic [PC_W-1:0]     rt_pc1,
    output logic [31:0]         rt_instr1,
    output logic                rt_skip1,
    output logic [63:0]         retire_cnt,
    output logic                deadlock
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [0:0]       state;
    logic [1:0]       c;
    logic [15:0]      wdog_cnt;
    logic [IDX_W-1:0] head_idx, head_idx1;
    logic             stall;

    // Slot views as packed arrays so the writeback logic is one generate body.
    logic [1:0]             s_wb;
    logic [1:0][LREG_W-1:0] s_lrd;
    logic [1:0][PREG_W-1:0] s_prd, s_old;
    logic [1:0]             s_wr;

    assign s_wb  = {head1_need_to_wb, head0_need_to_wb};
    assign s_lrd = {head1_lrd, head0_lrd};
    assign s_prd = {head1_prd, head0_prd};
    assign s_old = {head1_old_prd, head0_old_prd};

    // reset_n gates the strobes so nothing commits while reset is asserted.
    assign c[0] = reset_n && (state == RUN) && !flush && head0_deq && fl_ready;
    assign c[1] = c[0] && head1_deq;

    assign head_idx  = head_ptr[IDX_W-1:0];
    assign head_idx1 = head_idx + 1'b1;   // wraps mod ROB_SIZE by width

    genvar gi;
    generate
        for (gi = 0; gi < ROB_SIZE; gi++) begin : g_cv
            assign commit_vec[gi] = (c[0] && head_idx  == IDX_W'(gi)) ||
                                    (c[1] && head_idx1 == IDX_W'(gi));
        end
        // x0 is hardwired; such entries retire but free/rename nothing.
        for (gi = 0; gi < 2; gi++) begin : g_wr
            assign s_wr[gi] = c[gi] && s_wb[gi] && (s_lrd[gi] != '0);
        end
    endgenerate

    assign fl_push0      = s_wr[0];
    assign fl_push0_preg = s_old[0];
    assign fl_push1      = s_wr[1];
    assign fl_push1_preg = s_old[1];
    // Same-lrd collision: both enables go out, RAT gives slot 1 priority.
    assign art_we0       = s_wr[0];
    assign art_waddr0    = s_lrd[0];
    assign art_wdata0    = s_prd[0];
    assign art_we1       = s_wr[1];
    assign art_waddr1    = s_lrd[1];
    assign art_wdata1    = s_prd[1];

    // Head stalled: oldest entry present but not retiring (incl. fl_ready=0).
    assign stall = (state == RUN) && head0_valid && !c[0] && !flush;

    // HALT covers the flush cycles plus one cycle after flush drops, giving
    // the robentry array a clean cycle before retire resumes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)              state <= RUN;
        else if (flush)            state <= HALT;
        else if (state == HALT)    state <= RUN;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_ptr   <= '0;
            retire_cnt <= '0;
        end else begin
            head_ptr   <= flush ? '0
                               : head_ptr + (IDX_W+1)'(c[0]) + (IDX_W+1)'(c[1]);
            retire_cnt <= retire_cnt + 64'(c[0]) + 64'(c[1]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rt_valid0 <= 1'b0; rt_pc0 <= '0; rt_instr0 <= '0; rt_skip0 <= 1'b0;
            rt_valid1 <= 1'b0; rt_pc1 <= '0; rt_instr1 <= '0; rt_skip1 <= 1'b0;
        end else if (flush) begin
            rt_valid0 <= 1'b0; rt_pc0 <= '0; rt_instr0 <= '0; rt_skip0 <= 1'b0;
            rt_valid1 <= 1'b0; rt_pc1 <= '0; rt_instr1 <= '0; rt_skip1 <= 1'b0;
        end else begin
            rt_valid0 <= c[0];
            rt_valid1 <= c[1];
            if (c[0]) begin
                rt_pc0 <= head0_pc; rt_instr0 <= head0_instr; rt_skip0 <= head0_skip;
            end
            if (c[1]) begin
                rt_pc1 <= head1_pc; rt_instr1 <= head1_instr; rt_skip1 <= head1_skip;
            end
        end
    end

    // Counter saturates at the limit; deadlock is set on the edge that
    // brings it there, so WDOG_LIMIT stalled cycles raise the flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt <= '0;
            deadlock <= 1'b0;
        end else begin
            if (flush || c[0])
                wdog_cnt <= '0;
            else if (stall && wdog_cnt != 16'(WDOG_LIMIT))
                wdog_cnt <= wdog_cnt + 16'd1;
            if (stall && wdog_cnt >= 16'(WDOG_LIMIT - 1))
                deadlock <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
module tb_rob_commit_ctrl;
    localparam int PC_W = 39, LREG_W = 5, PREG_W = 7;

    logic              clock, reset_n, flush, fl_ready;
    logic              head0_valid, head0_deq, head0_need_to_wb, head0_skip;
    logic [PC_W-1:0]   head0_pc, head1_pc;
    logic [31:0]       head0_instr, head1_instr;
    logic [LREG_W-1:0] head0_lrd, head1_lrd;
    logic [PREG_W-1:0] head0_prd, head0_old_prd, head1_prd, head1_old_prd;
    logic              head1_deq, head1_need_to_wb, head1_skip;
    logic [63:0]       commit_vec;
    logic [6:0]        head_ptr;
    logic              fl_push0, fl_push1, art_we0, art_we1;
    logic [PREG_W-1:0] fl_push0_preg, fl_push1_preg, art_wdata0, art_wdata1;
    logic [LREG_W-1:0] art_waddr0, art_waddr1;
    logic              rt_valid0, rt_valid1, rt_skip0, rt_skip1;
    logic [PC_W-1:0]   rt_pc0, rt_pc1;
    logic [31:0]       rt_instr0, rt_instr1;
    logic [63:0]       retire_cnt;
    logic              deadlock;

    int          n_chk = 0, n_fail = 0;
    logic [6:0]  exp_head = '0;
    logic [63:0] exp_rc = '0;
    logic [63:0] one = 64'd1;

    rob_commit_ctrl #(.ROB_SIZE(64), .IDX_W(6), .WDOG_LIMIT(8),
                      .PC_W(PC_W), .LREG_W(LREG_W), .PREG_W(PREG_W)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .head0_valid(head0_valid), .head0_deq(head0_deq), .head0_pc(head0_pc),
        .head0_instr(head0_instr), .head0_lrd(head0_lrd), .head0_prd(head0_prd),
        .head0_old_prd(head0_old_prd), .head0_need_to_wb(head0_need_to_wb),
        .head0_skip(head0_skip),
        .head1_deq(head1_deq), .head1_pc(head1_pc), .head1_instr(head1_instr),
        .head1_lrd(head1_lrd), .head1_prd(head1_prd), .head1_old_prd(head1_old_prd),
        .head1_need_to_wb(head1_need_to_wb), .head1_skip(head1_skip),
        .fl_ready(fl_ready), .commit_vec(commit_vec), .head_ptr(head_ptr),
        .fl_push0(fl_push0), .fl_push0_preg(fl_push0_preg),
        .fl_push1(fl_push1), .fl_push1_preg(fl_push1_preg),
        .art_we0(art_we0), .art_waddr0(art_waddr0), .art_wdata0(art_wdata0),
        .art_we1(art_we1), .art_waddr1(art_waddr1), .art_wdata1(art_wdata1),
        .rt_valid0(rt_valid0), .rt_pc0(rt_pc0), .rt_instr0(rt_instr0), .rt_skip0(rt_skip0),
        .rt_valid1(rt_valid1), .rt_pc1(rt_pc1), .rt_instr1(rt_instr1), .rt_skip1(rt_skip1),
        .retire_cnt(retire_cnt), .deadlock(deadlock)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset_n = 0; flush = 0; fl_ready = 0;
        head0_valid = 0; head0_deq = 0; head0_pc = '0; head0_instr = '0;
        head0_lrd = '0; head0_prd = '0; head0_old_prd = '0;
        head0_need_to_wb = 0; head0_skip = 0;
        head1_deq = 0; head1_pc = '0; head1_instr = '0; head1_lrd = '0;
        head1_prd = '0; head1_old_prd = '0; head1_need_to_wb = 0; head1_skip = 0;
        #12 reset_n = 1;
        tick();
        n_chk++; if (head_ptr !== 7'd0) begin n_fail++; $display("FAIL reset_head got %h exp 0", head_ptr); end
        n_chk++; if (retire_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_rc got %0d exp 0", retire_cnt); end
        n_chk++; if ({deadlock, rt_valid0, rt_valid1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {deadlock, rt_valid0, rt_valid1}); end
        n_chk++; if (commit_vec !== 64'd0) begin n_fail++; $display("FAIL reset_cv got %h exp 0", commit_vec); end
    endtask

    // Five single-slot commits bring head to 5.
    task automatic test_single();
        fl_ready = 1; head0_deq = 1; head1_deq = 0;
        head0_need_to_wb = 1; head0_lrd = 5'd2;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++; if (commit_vec !== (one << exp_head[5:0])) begin n_fail++; $display("FAIL single_cv got %h exp %h", commit_vec, one << exp_head[5:0]); end
            tick(); exp_head += 7'd1; exp_rc += 64'd1;
        end
        n_chk++; if (head_ptr !== 7'd5) begin n_fail++; $display("FAIL single_head got %h exp 5", head_ptr); end
        n_chk++; if (retire_cnt !== exp_rc) begin n_fail++; $display("FAIL single_rc got %0d exp %0d", retire_cnt, exp_rc); end
    endtask

    task automatic test_dual();
        head0_deq = 1; head1_deq = 1;
        head0_lrd = 5'd3; head0_prd = 7'd40; head0_old_prd = 7'd17;
        head1_lrd = 5'd9; head1_prd = 7'd41; head1_old_prd = 7'd18; head1_need_to_wb = 1;
        head0_pc = 39'h1000; head1_pc = 39'h1004;
        head0_instr = 32'h0000_0013; head1_instr = 32'h00a0_0093; head1_skip = 1;
        #1;
        n_chk++; if (commit_vec !== 64'h60) begin n_fail++; $display("FAIL dual_cv got %h exp 60", commit_vec); end
        n_chk++; if ({fl_push0, fl_push1, fl_push0_preg, fl_push1_preg} !== {2'b11, 7'd17, 7'd18}) begin n_fail++; $display("FAIL dual_push got %b%b %0d %0d exp 11 17 18", fl_push0, fl_push1, fl_push0_preg, fl_push1_preg); end
        n_chk++; if ({art_we1, art_waddr1, art_wdata1} !== {1'b1, 5'd9, 7'd41}) begin n_fail++; $display("FAIL dual_art1 got %b %0d %0d exp 1 9 41", art_we1, art_waddr1, art_wdata1); end
        tick(); exp_head += 7'd2; exp_rc += 64'd2;
        n_chk++; if (head_ptr !== 7'd7) begin n_fail++; $display("FAIL dual_head got %h exp 7", head_ptr); end
        n_chk++; if (retire_cnt !== 64'd7) begin n_fail++; $display("FAIL dual_rc got %0d exp 7", retire_cnt); end
        n_chk++; if ({rt_valid0, rt_valid1, rt_pc0, rt_pc1, rt_instr1, rt_skip0, rt_skip1} !==
                     {2'b11, 39'h1000, 39'h1004, 32'h00a0_0093, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL dual_rt got v=%b%b pc=%h/%h i1=%h s=%b%b", rt_valid0, rt_valid1, rt_pc0, rt_pc1, rt_instr1, rt_skip0, rt_skip1);
        end
        head1_skip = 0;
    endtask

    // Dual commits up to 63, then the pair straddling the wrap.
    task automatic test_wrap();
        for (int i = 0; i < 28; i++) begin tick(); exp_head += 7'd2; exp_rc += 64'd2; end
        n_chk++; if (head_ptr !== 7'd63) begin n_fail++; $display("FAIL wrap_pre got %h exp 3f", head_ptr); end
        n_chk++; if (commit_vec !== 64'h8000_0000_0000_0001) begin n_fail++; $display("FAIL wrap_cv got %h exp 8000000000000001", commit_vec); end
        tick(); exp_head += 7'd2; exp_rc += 64'd2;
        n_chk++; if (head_ptr !== 7'h41) begin n_fail++; $display("FAIL wrap_head got %h exp 41", head_ptr); end
        n_chk++; if (retire_cnt !== 64'd65) begin n_fail++; $display("FAIL wrap_rc got %0d exp 65", retire_cnt); end
    endtask

    task automatic test_in_order();
        head0_deq = 0; head1_deq = 1; #1;
        n_chk++; if ({commit_vec, fl_push0, fl_push1, art_we1} !== 67'd0) begin n_fail++; $display("FAIL order_cv got %h push %b%b", commit_vec, fl_push0, fl_push1); end
        tick();
        n_chk++; if (head_ptr !== exp_head) begin n_fail++; $display("FAIL order_head got %h exp %h", head_ptr, exp_head); end
        head0_deq = 1; fl_ready = 0; #1;
        n_chk++; if (commit_vec !== 64'd0) begin n_fail++; $display("FAIL flrdy_cv got %h exp 0", commit_vec); end
        tick();
        n_chk++; if (retire_cnt !== exp_rc) begin n_fail++; $display("FAIL flrdy_rc got %0d exp %0d", retire_cnt, exp_rc); end
        fl_ready = 1;
    endtask

    task automatic test_writeback();
        head0_deq = 1; head1_deq = 0; head0_need_to_wb = 1; head0_lrd = 5'd0; #1;
        n_chk++; if ({commit_vec[exp_head[5:0]], fl_push0, art_we0} !== 3'b100) begin n_fail++; $display("FAIL lrd0 got c=%b push=%b we=%b exp 1 0 0", commit_vec[exp_head[5:0]], fl_push0, art_we0); end
        tick(); exp_head += 7'd1; exp_rc += 64'd1;
        head0_lrd = 5'd3; head0_old_prd = 7'd17; head0_prd = 7'd40; #1;
        n_chk++; if ({fl_push0, fl_push0_preg, art_we0, art_waddr0, art_wdata0} !== {1'b1, 7'd17, 1'b1, 5'd3, 7'd40}) begin n_fail++; $display("FAIL lrd3 got push=%b preg=%0d we=%b wa=%0d wd=%0d", fl_push0, fl_push0_preg, art_we0, art_waddr0, art_wdata0); end
        head0_need_to_wb = 0; #1;
        n_chk++; if ({fl_push0, art_we0} !== 2'b00) begin n_fail++; $display("FAIL nowb got %b%b exp 00", fl_push0, art_we0); end
        head0_need_to_wb = 1; head1_deq = 1; head1_lrd = 5'd3; head1_need_to_wb = 1; #1;
        n_chk++; if ({art_we0, art_we1, art_waddr0, art_waddr1, art_wdata1} !== {2'b11, 5'd3, 5'd3, 7'd41}) begin n_fail++; $display("FAIL samelrd got we=%b%b wa=%0d/%0d wd1=%0d", art_we0, art_we1, art_waddr0, art_waddr1, art_wdata1); end
        tick(); exp_head += 7'd2; exp_rc += 64'd2;
        n_chk++; if (head_ptr !== exp_head) begin n_fail++; $display("FAIL wb_head got %h exp %h", head_ptr, exp_head); end
    endtask

    task automatic test_flush();
        head0_deq = 1; head1_deq = 1; flush = 1; #1;
        n_chk++; if (commit_vec !== 64'd0) begin n_fail++; $display("FAIL flush_c1 got %h exp 0", commit_vec); end
        tick(); exp_head = '0;
        n_chk++; if ({head_ptr, rt_valid0, rt_valid1} !== 9'd0) begin n_fail++; $display("FAIL flush_head got %h rt=%b%b", head_ptr, rt_valid0, rt_valid1); end
        n_chk++; if (commit_vec !== 64'd0) begin n_fail++; $display("FAIL flush_c2 got %h exp 0", commit_vec); end
        tick(); flush = 0; #1;
        n_chk++; if (commit_vec !== 64'd0) begin n_fail++; $display("FAIL flush_c3 got %h exp 0", commit_vec); end
        tick();
        n_chk++; if ({head_ptr, retire_cnt} !== {7'd0, exp_rc}) begin n_fail++; $display("FAIL flush_hold got %h %0d", head_ptr, retire_cnt); end
        n_chk++; if (commit_vec !== 64'h3) begin n_fail++; $display("FAIL flush_resume got %h exp 3", commit_vec); end
        tick(); exp_head += 7'd2; exp_rc += 64'd2;
        n_chk++; if (head_ptr !== 7'd2) begin n_fail++; $display("FAIL flush_head2 got %h exp 2", head_ptr); end
    endtask

    task automatic test_watchdog();
        head0_valid = 1; head0_deq = 0; head1_deq = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) begin
                n_chk++; if (deadlock !== 1'b0) begin n_fail++; $display("FAIL wdog_early got %b exp 0", deadlock); end
            end
        end
        n_chk++; if (deadlock !== 1'b1) begin n_fail++; $display("FAIL wdog_set got %b exp 1", deadlock); end
        head0_deq = 1; tick(); exp_head += 7'd1; exp_rc += 64'd1;
        tick(); exp_head += 7'd1; exp_rc += 64'd1;
        n_chk++; if ({deadlock, head_ptr, retire_cnt} !== {1'b1, exp_head, exp_rc}) begin n_fail++; $display("FAIL wdog_sticky got %b %h %0d", deadlock, head_ptr, retire_cnt); end
    endtask

    task automatic test_reset_mid();
        head1_deq = 1; reset_n = 0; #1;
        n_chk++; if ({head_ptr, retire_cnt, deadlock, rt_valid0} !== 73'd0) begin n_fail++; $display("FAIL rstmid got h=%h rc=%0d dl=%b", head_ptr, retire_cnt, deadlock); end
        n_chk++; if ({commit_vec, fl_push0, art_we0} !== 66'd0) begin n_fail++; $display("FAIL rstmid_comb got %h", commit_vec); end
        tick(); #2 reset_n = 1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_wrap();
        test_in_order();
        test_writeback();
        test_flush();
        test_watchdog();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
